pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the five-stage pipeline registers (F/D, D/E, E/M, M/W) and the PC register.
- Generates per-stage enable and flush strobes for three cases: load-use hazards, taken branches/jumps resolved in Execute, and multi-cycle data-memory waits.
- Holds a small FSM for memory-wait freezing with a watchdog, plus saturating stall and flush performance counters.

Parameters:
- DATA_WIDTH, 32, width of the performance counter outputs.
- REG_ADDR_WIDTH, 5, register index width.
- MAX_WAIT, 255, maximum consecutive memory-wait cycles before the timeout error is raised.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rs1D_i  in  REG_ADDR_WIDTH  source reg 1 of the instruction in Decode
- rs2D_i  in  REG_ADDR_WIDTH  source reg 2 of the instruction in Decode
- rdE_i  in  REG_ADDR_WIDTH  destination reg of the instruction in Execute
- memReadE_i  in  1  Execute instruction is a load
- branchTakenE_i  in  1  branch/jump resolved taken in Execute
- memReqM_i  in  1  Memory stage is issuing a data-memory access
- memReadyM_i  in  1  data memory completes the access this cycle
- enPC_o  out  1  PC register enable
- enD_o  out  1  F/D register enable
- enE_o  out  1  D/E register enable
- enM_o  out  1  E/M register enable
- enW_o  out  1  M/W register enable
- flushD_o  out  1  F/D register loads a bubble (NOP)
- flushE_o  out  1  D/E register loads a bubble
- stallCnt_o  out  DATA_WIDTH  cycles with PC held
- flushCnt_o  out  DATA_WIDTH  branch flush events
- memTimeout_o  out  1  sticky watchdog error

Behaviour:
- Clock port is clk; reset is rst, synchronous and active-high. No asynchronous reset.
- While rst=1:
  - all en*_o=0, flushD_o=flushE_o=1;
  - registered next values: state=RUN, waitCnt=0, stallCnt=0, flushCnt=0, memTimeout=0.
  - First cycle after rst falls: state RUN, outputs per RUN rules.
- Outputs are combinational (Mealy) from current state and inputs. Counters and flags are registered.
- FSM states: RUN, MEM_WAIT.
- RUN transitions:
  - memReqM_i=1 and memReadyM_i=0 -> MEM_WAIT.
  - Same-cycle ready (memReadyM_i=1) stays in RUN with no stall.
- MEM_WAIT transitions:
  - memReadyM_i=1 -> RUN.
  - rst forces RUN.
  - memReqM_i dropping to 0 without ready -> RUN; this is a protocol violation, flagged by a bench assertion.
- Freeze condition: state==MEM_WAIT and memReadyM_i=0, or state==RUN with memReqM_i=1 and memReadyM_i=0.
  - All five enables are 0; both flushes are 0.
  - Freeze has highest priority and masks both branch and load-use actions.
  - The completing (ready) cycle is not frozen.
- Branch (not frozen, branchTakenE_i=1):
  - flushD_o=1, flushE_o=1, all enables 1.
  - Masks load-use, because the Decode instruction is discarded.
- Load-use (not frozen, no branch, memReadE_i=1, rdE_i!=0, rdE_i==rs1D_i or rdE_i==rs2D_i):
  - enPC_o=0, enD_o=0, flushE_o=1, enE_o/enM_o/enW_o=1.
  - Exactly one bubble, because the load has advanced to Memory next cycle.
- Otherwise: all enables 1, flushes 0.
- stallCnt increments on every cycle with enPC_o=0 outside reset.
- flushCnt increments on each branch flush cycle.
- Both counters saturate at all-ones; no wrap.
- waitCnt:
  - increments each frozen cycle; cleared on leaving MEM_WAIT;
  - when it reaches MAX_WAIT, memTimeout_o is set and stays 1 until rst;
  - waitCnt saturates at MAX_WAIT, and the freeze continues.
- rst asserted mid-MEM_WAIT aborts the wait immediately; there is no replay.

Decomposition:
- Shared package (pipeline_pkg):
  - state enum {RUN, MEM_WAIT};
  - REG_ADDR_WIDTH and NOP encoding constants, also used by pipeline registers for bubble insertion.
- One natural sub-module: sat_counter (parameterised width, inc, rst, saturating). Instantiated for stallCnt, flushCnt and waitCnt, with max value as a parameter.
- Hazard compare logic stays inline.

Test Plan:
- Load-use:
  - Stimulus: memReadE_i=1, rdE_i=5, rs1D_i=5 for one cycle.
  - Required: enPC_o=enD_o=0, flushE_o=1 that cycle; all enables 1 next cycle; stallCnt_o=1.
- Branch/load-use collision:
  - Stimulus: branchTakenE_i=1 with the load-use condition also true.
  - Required: flushD_o=flushE_o=1, enPC_o=1, stallCnt_o unchanged, flushCnt_o=1.
- Memory wait:
  - Stimulus: memReqM_i=1, memReadyM_i=0 for 3 cycles, then 1.
  - Required: 3 cycles of all-enables-0; ready cycle all 1; state RUN after; stallCnt_o=3.
- Watchdog:
  - Stimulus: MAX_WAIT=4, memReadyM_i held 0 for 6 cycles.
  - Required: memTimeout_o=1 from the 5th edge onward, freeze persists; stays 1 after ready until rst.
- Reset mid-wait:
  - Stimulus: rst=1 during MEM_WAIT, released after 2 cycles with memReqM_i=0.
  - Required: counters 0, memTimeout_o=0, all enables 1 on the first post-reset cycle.
- rd=x0:
  - Stimulus: memReadE_i=1, rdE_i=0, rs1D_i=0.
  - Required: no stall.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: controller states, register-index width and the
// bubble encoding that the pipeline registers load when flushed.
package pipeline_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  // addi x0, x0, 0 -- the canonical bubble inserted on a flush
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX_VAL instead of wrapping; clr and rst both zero it.
module sat_counter #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != MAX_VAL)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stage enable/flush sequencing for load-use, taken-branch and data-memory-wait
// hazards, with a memory-wait watchdog and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = pipeline_pkg::REG_ADDR_WIDTH,
  parameter int MAX_WAIT       = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdE_i,
  input  logic                      memReadE_i,
  input  logic                      branchTakenE_i,
  input  logic                      memReqM_i,
  input  logic                      memReadyM_i,
  output logic                      enPC_o,
  output logic                      enD_o,
  output logic                      enE_o,
  output logic                      enM_o,
  output logic                      enW_o,
  output logic                      flushD_o,
  output logic                      flushE_o,
  output logic [DATA_WIDTH-1:0]     stallCnt_o,
  output logic [DATA_WIDTH-1:0]     flushCnt_o,
  output logic                      memTimeout_o
);

  import pipeline_pkg::*;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t            state_reg, state_next;
  logic              frozen;
  logic              load_use;
  logic              branch_flush;
  logic              timeout_reg;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        perf_inc;
  logic [DATA_WIDTH-1:0] perf_cnt [2];

  assign load_use = memReadE_i && (rdE_i != '0) &&
                    ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    frozen       = 1'b0;
    branch_flush = 1'b0;
    enPC_o       = 1'b1;
    enD_o        = 1'b1;
    enE_o        = 1'b1;
    enM_o        = 1'b1;
    enW_o        = 1'b1;
    flushD_o     = 1'b0;
    flushE_o     = 1'b0;

    case (state_reg)
      RUN: begin
        frozen = memReqM_i && !memReadyM_i;
        if (frozen) state_next = MEM_WAIT;
      end
      MEM_WAIT: begin
        frozen = !memReadyM_i;
        // Dropping the request without ready is a protocol error; recover to RUN.
        if (memReadyM_i || !memReqM_i) state_next = RUN;
      end
      default: state_next = RUN;
    endcase

    if (rst) begin
      frozen     = 1'b0;
      state_next = RUN;
      enPC_o     = 1'b0;
      enD_o      = 1'b0;
      enE_o      = 1'b0;
      enM_o      = 1'b0;
      enW_o      = 1'b0;
      flushD_o   = 1'b1;
      flushE_o   = 1'b1;
    end else if (frozen) begin
      enPC_o = 1'b0;
      enD_o  = 1'b0;
      enE_o  = 1'b0;
      enM_o  = 1'b0;
      enW_o  = 1'b0;
    end else if (branchTakenE_i) begin
      // The Decode instruction is discarded, so a load-use match is irrelevant.
      branch_flush = 1'b1;
      flushD_o     = 1'b1;
      flushE_o     = 1'b1;
    end else if (load_use) begin
      enPC_o   = 1'b0;
      enD_o    = 1'b0;
      flushE_o = 1'b1;
    end
  end

  assign perf_inc[0] = !enPC_o && !rst;
  assign perf_inc[1] = branch_flush;

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    sat_counter #(
      .WIDTH (DATA_WIDTH)
    ) u_perf_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .inc   (perf_inc[gi]),
      .count (perf_cnt[gi])
    );
  end

  // Any unfrozen cycle ends the wait, so clearing on !frozen covers leaving MEM_WAIT.
  sat_counter #(
    .WIDTH   (WAIT_W),
    .MAX_VAL (WAIT_W'(MAX_WAIT))
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (!frozen),
    .inc   (frozen),
    .count (wait_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_reg <= 1'b0;
    end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
      timeout_reg <= 1'b1;
    end
  end

  assign stallCnt_o   = perf_cnt[0];
  assign flushCnt_o   = perf_cnt[1];
  assign memTimeout_o = timeout_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed vector table plus saturation sequences for pipeline_hazard_ctrl,
// built with a 4-bit counter width and a watchdog limit of 4 cycles.
module tb_pipeline_hazard_ctrl;

  localparam int DW = 4;
  localparam int AW = 5;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1, rs2, rd;
  logic          mem_read, branch, req, ready;
  logic          en_pc, en_d, en_e, en_m, en_w, flush_d, flush_e, timeout;
  logic [DW-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .DATA_WIDTH     (DW),
    .REG_ADDR_WIDTH (AW),
    .MAX_WAIT       (MW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rs1D_i         (rs1),
    .rs2D_i         (rs2),
    .rdE_i          (rd),
    .memReadE_i     (mem_read),
    .branchTakenE_i (branch),
    .memReqM_i      (req),
    .memReadyM_i    (ready),
    .enPC_o         (en_pc),
    .enD_o          (en_d),
    .enE_o          (en_e),
    .enM_o          (en_m),
    .enW_o          (en_w),
    .flushD_o       (flush_d),
    .flushE_o       (flush_e),
    .stallCnt_o     (stall_cnt),
    .flushCnt_o     (flush_cnt),
    .memTimeout_o   (timeout)
  );

  // Memory protocol monitor: once waiting, the request must be held until ready.
  logic in_wait = 1'b0;
  always @(posedge clk) begin
    if (!rst && in_wait && !req && !ready)
      $error("memory request dropped during wait");
    if (rst) in_wait <= 1'b0;
    else     in_wait <= req && !ready;
  end

  typedef struct {
    logic          rst;
    logic          mem_read;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          branch;
    logic          req;
    logic          ready;
    logic [4:0]    en;      // {pc, d, e, m, w}
    logic          fd;
    logic          fe;
    int            stall;
    int            flush;
    logic          to;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic mr, input int rdv, input int r1,
                              input int r2, input logic br, input logic rq, input logic rdy,
                              input logic [4:0] en, input logic fd, input logic fe,
                              input int st, input int fl, input logic to);
    vec_t v;
    v.rst = r; v.mem_read = mr; v.rd = AW'(rdv); v.rs1 = AW'(r1); v.rs2 = AW'(r2);
    v.branch = br; v.req = rq; v.ready = rdy;
    v.en = en; v.fd = fd; v.fe = fe; v.stall = st; v.flush = fl; v.to = to;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, required %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic mr, input int rdv, input int r1,
                       input int r2, input logic br, input logic rq, input logic rdy);
    rst = r; mem_read = mr; rd = AW'(rdv); rs1 = AW'(r1); rs2 = AW'(r2);
    branch = br; req = rq; ready = rdy;
  endtask

  initial begin
    //          rst mr rd r1 r2 br rq rdy  en        fd fe st fl to
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 1, 0, 0, 0)); // reset
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0, 0, 0)); // idle
    vecs.push_back(mk(0, 1, 5, 5, 0, 0, 0, 0, 5'b00111, 0, 1, 0, 0, 0)); // load-use rs1
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 7, 3, 7, 0, 0, 0, 5'b00111, 0, 1, 1, 0, 0)); // load-use rs2
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 2, 0, 0)); // rd = x0
    vecs.push_back(mk(0, 0, 5, 5, 0, 0, 0, 0, 5'b11111, 0, 0, 2, 0, 0)); // not a load
    vecs.push_back(mk(0, 1, 5, 5, 0, 1, 0, 0, 5'b11111, 1, 1, 2, 0, 0)); // branch + load-use
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 5'b11111, 1, 1, 2, 1, 0)); // branch alone
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 2, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 0, 2, 2, 0)); // wait 1
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 0, 3, 2, 0)); // wait 2
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 5'b00000, 0, 0, 4, 2, 0)); // wait 3, branch masked
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 5'b11111, 0, 0, 5, 2, 0)); // ready
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 5'b11111, 0, 0, 5, 2, 0)); // same-cycle ready
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 5, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 0, 5, 2, 0)); // watchdog wait 1
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 0, 6, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 0, 7, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 0, 8, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 0, 9, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 0, 10, 2, 1)); // timeout after 5th edge
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 5'b11111, 0, 0, 11, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 11, 2, 1)); // sticky
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 0, 11, 2, 1)); // enter wait
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 1, 12, 2, 1)); // reset mid-wait
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0, 0, 0)); // first post-reset

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      #1;
      drive(vecs[i].rst, vecs[i].mem_read, int'(vecs[i].rd), int'(vecs[i].rs1),
            int'(vecs[i].rs2), vecs[i].branch, vecs[i].req, vecs[i].ready);
      @(negedge clk);
      check("enables", i, int'({en_pc, en_d, en_e, en_m, en_w}), int'(vecs[i].en));
      check("flushD", i, int'(flush_d), int'(vecs[i].fd));
      check("flushE", i, int'(flush_e), int'(vecs[i].fe));
      check("stallCnt", i, int'(stall_cnt), vecs[i].stall);
      check("flushCnt", i, int'(flush_cnt), vecs[i].flush);
      check("memTimeout", i, int'(timeout), int'(vecs[i].to));
      $display("step %0d: en=%05b fd=%0b fe=%0b stall=%0d flush=%0d timeout=%0b",
               i, {en_pc, en_d, en_e, en_m, en_w}, flush_d, flush_e,
               stall_cnt, flush_cnt, timeout);
      @(posedge clk);
    end

    // Counter saturation: 17 stall cycles then 17 branch flushes on 4-bit counters.
    for (int k = 0; k < 17; k++) begin
      #1 drive(0, 1, 9, 9, 0, 0, 0, 0);
      @(posedge clk);
    end
    #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("stallCnt saturated", 100, int'(stall_cnt), 15);
    $display("saturation stall: stall=%0d", stall_cnt);
    @(posedge clk);

    for (int k = 0; k < 17; k++) begin
      #1 drive(0, 0, 0, 0, 0, 1, 0, 0);
      @(posedge clk);
    end
    #1 drive(0, 1, 9, 9, 0, 0, 0, 0);
    @(negedge clk);
    check("flushCnt saturated", 101, int'(flush_cnt), 15);
    check("stallCnt held", 101, int'(stall_cnt), 15);
    check("load-use at saturation", 101, int'({en_pc, en_d, en_e, en_m, en_w}), 5'b00111);
    $display("saturation flush: flush=%0d stall=%0d", flush_cnt, stall_cnt);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("stallCnt no wrap", 102, int'(stall_cnt), 15);
    $display("post saturation: stall=%0d flush=%0d", stall_cnt, flush_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
